// File: rtl/pipelined_carry_adder_pkg.sv
// Shared defaults and elaboration-time helpers for pipelined_carry_adder.
// The optional subtract mode in the top is enabled by defining PIPE_ADD_SUB_EN.
package pipe_add_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_carry_adder_chunk.sv
// Combinational W-bit adder slice with carry-in and carry-out; one instance per
// pipeline stage of pipelined_carry_adder.
module carry_chunk_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit adder split into STAGES registered chunk adds with valid/ready streaming.
// Define PIPE_ADD_SUB_EN to add the `sub` port (A - B via inverted B and carry-in).
module pipelined_carry_adder
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef PIPE_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             c_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             c_o
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_carry_adder: need 1 <= STAGES <= WIDTH and WIDTH a multiple of STAGES");
    end

    logic             w_en;
    logic             w_sub;
    logic             w_cin0;
    logic [WIDTH-1:0] w_b0;

`ifdef PIPE_ADD_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Subtraction folds into stage 0 only; the inverted upper B chunks ride the skew registers.
    assign w_b0     = B ^ {WIDTH{w_sub}};
    assign w_cin0   = c_i ^ w_sub;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int W_IN = WIDTH - k * CHUNK;
        localparam int W_LO = (k + 1) * CHUNK;

        logic [W_IN-1:0]  w_a_in;
        logic [W_IN-1:0]  w_b_in;
        logic             w_vin;
        logic             w_cin;
        logic             w_cout;
        logic [CHUNK-1:0] w_sum;
        logic [W_LO-1:0]  w_lo_nxt;
        logic [W_LO-1:0]  r_sum;
        logic             r_valid;
        logic             r_carry;

        if (k == 0) begin : g_head
            assign w_a_in   = A;
            assign w_b_in   = w_b0;
            assign w_cin    = w_cin0;
            assign w_vin    = in_valid;
            assign w_lo_nxt = w_sum;
        end else begin : g_body
            assign w_a_in   = g_stage[k-1].g_fwd.r_a;
            assign w_b_in   = g_stage[k-1].g_fwd.r_b;
            assign w_cin    = g_stage[k-1].r_carry;
            assign w_vin    = g_stage[k-1].r_valid;
            assign w_lo_nxt = {w_sum, g_stage[k-1].r_sum};
        end

        carry_chunk_adder #(
            .W (CHUNK)
        ) u_chunk (
            .i_a    (w_a_in[CHUNK-1:0]),
            .i_b    (w_b_in[CHUNK-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_sum),
            .o_cout (w_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_vin;
                r_carry <= w_cout;
                r_sum   <= w_lo_nxt;
            end
        end

        // Operand chunks not yet added are skewed forward; the last stage has none left.
        if (k < STAGES - 1) begin : g_fwd
            logic [W_IN-CHUNK-1:0] r_a;
            logic [W_IN-CHUNK-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_in[W_IN-1:CHUNK];
                    r_b <= w_b_in[W_IN-1:CHUNK];
                end
            end
        end
    end

    assign S         = g_stage[STAGES-1].r_sum;
    assign c_o       = g_stage[STAGES-1].r_carry;
    assign out_valid = g_stage[STAGES-1].r_valid;

endmodule
